tap_tick_timer: RTL
===================

# tap_tick_timer

Downstream consumer of the 4-bit frequency divider. Selects one divider tap and turns its rising edges into single-cycle `Tick` enables in the `Clock` domain. Counts a programmed number of ticks and reports completion with a one-cycle `Done` pulse, giving the design a coarse, tap-scaled interval timer.

## Interface
Parameters:
- `WIDTH`, default 8: width of the tick-count load value and of `Remaining`.

Ports (one clock; reset is asynchronous and active-high):
- `Clock` in 1: sole clock, rising edge.
- `Clear` in 1: asynchronous, active-high reset.
- `Freq_Div` in 4: divider outputs, registered on `Clock`; bit k has period 2^(k+1) cycles.
- `Sel` in 2: tap index, sampled only when a start is accepted.
- `Start` in 1: start request, level-sampled each cycle.
- `Load` in WIDTH: number of ticks to count, sampled with `Start`.
- `Tick` out 1: one-cycle pulse per rising edge of the selected tap.
- `Busy` out 1: high in RUN.
- `Done` out 1: one-cycle completion pulse.
- `Remaining` out WIDTH: ticks left in the current interval.

## Operation
- Internal registers:
  - `sel_r` (2 bits): latched tap index.
  - `tap_q`: previous value of the selected tap.
  - `load_r` (WIDTH): latched `Load`.
  - `state`: 2 bits, one of IDLE, RUN, DONE.
- Edge event: `e = Freq_Div[sel_r] & ~tap_q`, combinational.
  - `tap_q <= Freq_Div[sel_r]` every cycle.
  - When `sel_r` changes at start acceptance, `tap_q` loads `Freq_Div[Sel]` (the new tap) so that no spurious edge is seen.
- `Tick <= e` every cycle, in every state. It is free-running on `sel_r`.
- IDLE:
  - `Start=1` and `Load!=0`: go to RUN; `Remaining<=Load`, `load_r<=Load`, `sel_r<=Sel`.
  - `Start=1` and `Load==0`: go to DONE; `sel_r<=Sel`, `Remaining` stays 0.
- RUN:
  - On `e`, `Remaining` decrements by 1.
  - On `e` with `Remaining==1`: `Remaining<=0`, go to DONE.
  - `Start` is ignored.
- DONE: `Done=1` for exactly this cycle, then go to IDLE. `Start` is ignored.
- Outputs are decoded from state: `Busy = (state==RUN)`, `Done = (state==DONE)`.
- Arithmetic: `Remaining` never decrements below 0 and never wraps. Counts of 1 to 2^WIDTH−1 ticks are supported.

## Timing
- Reset values, while `Clear=1` and after it deasserts:
  - `Tick=0`, `Busy=0`, `Done=0`, `Remaining=0`.
  - `state=IDLE`, `sel_r=0`, `tap_q=0`, `load_r=0`.
- `Tick` latency: rises 1 cycle after the cycle in which `Freq_Div[sel_r]` first reads 1.
- Start acceptance: `Busy` is high starting the cycle after `Start` is sampled in IDLE.
- Tick count: the first counted edge is the first rising edge that `tap_q` sees after acceptance.
- Completion: `Done` is high on the cycle after the edge that takes `Remaining` to 0. That is the same cycle as the corresponding `Tick`, and `Busy` is low in that cycle.
- `Load==0` start: `Done` is high 1 cycle after acceptance. `Busy` never asserts.
- Back-to-back runs: a `Start` in the cycle after `Done` is accepted, because the block is in IDLE then.
- `Clear` mid-operation: everything returns to reset values immediately. No `Done` is issued.
- A tap held constant high or low generates no ticks. RUN persists until `Clear`.

## Configuration
- Macro `TAP_TICK_TIMER_RELOAD_EN`.
- Defined (periodic mode):
  - DONE goes to RUN with `Remaining<=load_r`, so `Done` pulses every `load_r` ticks.
  - `Start=1` with `Load==0` while in RUN or DONE stops the timer. The next state is IDLE, and no `Done` is issued for that cycle's transition.
  - Other `Start` values in RUN or DONE are ignored.
  - A `Load==0` start from IDLE still produces a single `Done` and returns to IDLE.
- Undefined: one-shot behaviour exactly as in Operation. No stop path exists other than `Clear`.

## Test plan
- Reset: hold `Clear=1` with the divider running → `Tick`, `Busy`, `Done` stay 0 and `Remaining=0`. Release → still 0 until a start is issued.
- One-shot, fastest tap: `Sel=0`, `Load=3`, 1-cycle `Start` → `Tick` every 2 cycles; `Remaining` steps 3→2→1→0; one `Done` pulse coincides with the 3rd `Tick`; `Busy` is high for about 6 cycles.
- Slow tap: `Sel=2`, `Load=2` → `Tick` every 8 cycles; `Done` within 16–17 cycles of acceptance; `Start` pulsed mid-run is ignored and `Remaining` is unaffected.
- Zero load: `Sel=1`, `Load=0` → `Done=1` exactly 1 cycle after `Start`; `Busy` never asserts.
- Async reset mid-run: `Sel=3`, `Load=5`, assert `Clear` after 2 ticks → outputs zero immediately; no `Done`; a fresh `Start` with `Load=1` then completes normally.
- With `TAP_TICK_TIMER_RELOAD_EN`: `Sel=0`, `Load=2` → `Done` every 4 cycles for 3 periods. Then `Start` with `Load=0` → `Busy` falls next cycle and no further `Done` follows.

Source files
------------

// File: rtl/tap_tick_timer.sv
// Tap-scaled interval timer: turns rising edges of one divider tap into Tick pulses and counts them down.
// Optional periodic mode via `define TAP_TICK_TIMER_RELOAD_EN (undefined: one-shot).
module tap_tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [3:0]       Freq_Div,
  input  logic [1:0]       Sel,
  input  logic             Start,
  input  logic [WIDTH-1:0] Load,
  output logic             Tick,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Remaining,
  output logic [1:0]       Dbg_State
);

  // Handshake: Start/Load/Sel are level-sampled on each Clock edge with no ready;
  // a request is accepted only in IDLE (or, in periodic mode, a Load==0 stop in RUN/DONE).

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       sel_r, sel_nxt;
  logic             tap_q, tap_nxt;
  logic [WIDTH-1:0] load_r, load_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic             e;

  assign e = Freq_Div[sel_r] & ~tap_q;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_r;
    tap_nxt   = Freq_Div[sel_r];
    load_nxt  = load_r;
    rem_nxt   = Remaining;
    case (state)
      IDLE: begin
        if (Start) begin
          sel_nxt = Sel;
          // Track the newly selected tap so switching taps cannot fake an edge.
          tap_nxt = Freq_Div[Sel];
          // A zero load is latched too, so periodic mode knows not to rearm.
          load_nxt = Load;
          if (Load != '0) begin
            state_nxt = RUN;
            rem_nxt   = Load;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
`ifdef TAP_TICK_TIMER_RELOAD_EN
        if (Start && (Load == '0)) begin
          state_nxt = IDLE;
        end else
`endif
        if (e && (Remaining != '0)) begin
          rem_nxt = Remaining - WIDTH'(1);
          if (Remaining == WIDTH'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
`ifdef TAP_TICK_TIMER_RELOAD_EN
        if (!(Start && (Load == '0)) && (load_r != '0)) begin
          state_nxt = RUN;
          rem_nxt   = load_r;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state     <= IDLE;
      sel_r     <= 2'd0;
      tap_q     <= 1'b0;
      load_r    <= '0;
      Remaining <= '0;
      Tick      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel_r     <= sel_nxt;
      tap_q     <= tap_nxt;
      load_r    <= load_nxt;
      Remaining <= rem_nxt;
      Tick      <= e;
    end
  end

  assign Busy      = (state == RUN);
  assign Done      = (state == DONE);
  assign Dbg_State = state;

endmodule
